rx_udp_filter: RTL
==================

Name: rx_udp_filter

Overview:
- Receive-side UDP layer for the byte-wide AXI-Stream Ethernet path; sits after IP header stripping.
- Captures the 8-byte UDP header and filters on destination port against a table of NUM_PORTS entries.
- Forwards the payload, trimmed to the UDP length field; trailing Ethernet pad bytes are discarded.
- Adds real backpressure, error reporting and frame counters.
- With udp_enable low, the block is a combinational pass-through.

Parameters:
- NUM_PORTS, 2, number of accepted destination ports (1..8).
- CNT_W, 16, width of the statistics counters.
- FILTER_EN, 1, 1 = drop frames whose dest port matches no table entry; 0 = accept all.

Ports:
- s_axis_aclk  in  1  clock.
- s_axis_rst  in  1  synchronous active-high reset.
- udp_enable  in  1  0 = bypass: m_axis_* = s_axis_*, s_axis_tready = m_axis_tready.
- cfg_ports  in  16*NUM_PORTS  port table; entry i = bits [16i+15:16i].
- UDP_SrcPort, UDP_DestPort, UDP_TotLen, UDP_CheckSum  out  16 each  header of the last header-complete frame.
- hdr_valid  out  1  one-cycle pulse when the header is captured.
- port_idx  out  3  matching table index, valid with hdr_valid.
- err_short  out  1  pulse: input tlast arrived before UDP_TotLen bytes.
- err_len  out  1  pulse: UDP_TotLen < 8.
- frames_ok, frames_drop  out  CNT_W  saturating counters.
- s_axis_tdata[7:0], s_axis_tvalid, s_axis_tlast, s_axis_tuser (SOF)  in; s_axis_tready  out.
- m_axis_tdata[7:0], m_axis_tvalid, m_axis_tlast, m_axis_tuser (SOF of payload)  out; m_axis_tready  in.

Behaviour:
- Reset values: state IDLE; all outputs 0 except s_axis_tready = 1 and m_axis_tdata = 8'hff; counters 0. Reset mid-frame aborts the frame with no counter update; the frame remainder is ignored until the next SOF.
- A byte transfers only on s_axis_tvalid & s_axis_tready.
- IDLE: tready = 1. A transfer with tuser = 1 is byte 0 -> HEADER, byte count = 1. Non-SOF bytes are dropped silently.
- HEADER: bytes 0..7 are captured big-endian into the header registers.
  - On byte 7 transfer: hdr_valid pulses the next cycle.
  - Next state is DATA if TotLen >= 9 and the port is accepted.
  - TotLen == 8: IDLE if the byte carried tlast, else DROP; frames_ok++.
  - TotLen < 8: err_len, frames_drop++, DROP (IDLE if tlast).
  - Port rejected: frames_drop++, DROP (IDLE if tlast).
  - tlast on bytes 0..6: err_short, frames_drop++, IDLE.
- Port match: lowest matching index wins. With FILTER_EN = 0 or no match, port_idx = 0.
- DATA: the remaining counter is loaded with TotLen-8 and decremented per transfer.
  - Single output register; s_axis_tready = !m_axis_tvalid | m_axis_tready. Latency is 1 cycle, and full throughput is held under continuous tready.
  - The first payload byte carries m_axis_tuser = 1.
  - When the remaining count hits 1: m_axis_tlast = 1, frames_ok++. Next state is IDLE if the input byte also had tlast, else DROP (pad discard).
  - Input tlast with remaining > 1: m_axis_tlast = 1 on that byte, err_short, frames_drop++, IDLE.
- DROP: tready = 1 and the output is idle; input tlast -> IDLE. A new SOF seen in DROP starts HEADER (treated as a missing tlast; no error).
- Output register: holds data and flags while m_axis_tvalid & !m_axis_tready. m_axis_tvalid clears after the tlast byte is accepted.
- Counters saturate at all-ones. Simultaneous ok/drop in one cycle cannot occur.
- Bypass: udp_enable is sampled by the output muxes only. Toggling it mid-frame is unsupported. Internal state still tracks frames while bypassed, but counters freeze.

Decomposition:
- Package rx_udp_pkg: state enum (IDLE, HEADER, DATA, DROP), UDP_HDR_BYTES = 8, header field byte offsets.
- One sub-module, axis_out_reg: the one-entry output register with the ready/valid handshake, reusable by the other rx layers.

Test Plan:
- Dest port 0x1234 (table {0x1234, 0x5678}), TotLen 0x000C, 4 payload bytes A0..A3, tlast on A3 -> m_axis: A0(tuser) A1 A2 A3(tlast); port_idx = 0; frames_ok = 1.
- TotLen 0x000A, 2 payload bytes + 16 pad bytes, tlast on the last pad -> output B0, B1(tlast); pad consumed; no error.
- Dest port 0x9999, FILTER_EN = 1 -> no m_axis traffic; frames_drop = 1. A back-to-back valid frame then passes.
- TotLen 0x0010, tlast after 3 payload bytes -> 3 bytes out, tlast on the 3rd; err_short pulse; frames_drop = 1.
- 64-byte payload with m_axis_tready toggling every 2 cycles -> no loss or duplication; data stable while stalled.
- TotLen 0x0004 -> err_len pulse, frame dropped. Reset asserted mid-payload -> outputs return to reset values; the next frame is parsed correctly.

Source files
------------

// File: rtl/rx_udp_pkg.sv
// Shared types and header layout for the receive-side UDP layer.
package rx_udp_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DROP} state_t;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned HDR_W         = 8 * UDP_HDR_BYTES;

  localparam int unsigned SRC_OFF  = 0;
  localparam int unsigned DST_OFF  = 2;
  localparam int unsigned LEN_OFF  = 4;
  localparam int unsigned CSUM_OFF = 6;

  // Extract a big-endian 16-bit field starting at byte offset off.
  function automatic logic [15:0] hdr_field(input logic [HDR_W-1:0] hdr, input int unsigned off);
    return 16'(hdr >> (HDR_W - 16 - 8 * off));
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: full throughput, holds its payload while stalled.
module axis_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_user,
  output logic              in_ready_c,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_user,
  input  logic              out_ready
);

  assign in_ready_c = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
        out_user <= in_user;
      end else begin
        out_last <= 1'b0;
        out_user <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_udp_filter.sv
// UDP receive layer: header capture, destination-port filter, length trim and frame statistics.
module rx_udp_filter
  import rx_udp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CNT_W     = 16,
  parameter bit          FILTER_EN = 1'b1
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_rst,
  input  logic                   udp_enable,
  input  logic [16*NUM_PORTS-1:0] cfg_ports,
  output logic [15:0]            UDP_SrcPort,
  output logic [15:0]            UDP_DestPort,
  output logic [15:0]            UDP_TotLen,
  output logic [15:0]            UDP_CheckSum,
  output logic                   hdr_valid,
  output logic [2:0]             port_idx,
  output logic                   err_short,
  output logic                   err_len,
  output logic [CNT_W-1:0]       frames_ok,
  output logic [CNT_W-1:0]       frames_drop,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic                   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic                   m_axis_tready
);

  state_t            state;
  logic [2:0]        byte_cnt;
  logic [HDR_W-9:0]  hdr_sr;
  logic [15:0]       rem;
  logic              first;

  logic [HDR_W-1:0]  hdr_full;
  logic [15:0]       hdr_dest, hdr_len;
  logic              match_hit, accept;
  logic [2:0]        match_idx;
  logic              xfer, sof_start, hdr_beat, tready_int, or_ready_c, or_out_ready;
  logic [2:0]        beat_idx;
  logic [7:0]        or_data;
  logic              or_valid, or_last, or_user;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign hdr_full = {hdr_sr, s_axis_tdata};
  assign hdr_dest = hdr_field(hdr_full, DST_OFF);
  assign hdr_len  = hdr_field(hdr_full, LEN_OFF);

  // Lowest matching table entry wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!match_hit && 16'(cfg_ports >> (16 * i)) == hdr_dest) begin
        match_hit = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  assign accept = !FILTER_EN || match_hit;

  assign tready_int    = (state == DATA) ? or_ready_c : 1'b1;
  assign s_axis_tready = udp_enable ? tready_int : m_axis_tready;
  assign xfer          = s_axis_tvalid && s_axis_tready;
  assign sof_start     = xfer && s_axis_tuser && (state == IDLE || state == DROP);
  assign hdr_beat      = sof_start || (xfer && state == HEADER);
  assign beat_idx      = sof_start ? 3'd0 : byte_cnt;
  assign or_out_ready  = udp_enable ? m_axis_tready : 1'b1;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      hdr_sr       <= '0;
      rem          <= '0;
      first        <= 1'b0;
      UDP_SrcPort  <= '0;
      UDP_DestPort <= '0;
      UDP_TotLen   <= '0;
      UDP_CheckSum <= '0;
      hdr_valid    <= 1'b0;
      port_idx     <= '0;
      err_short    <= 1'b0;
      err_len      <= 1'b0;
      frames_ok    <= '0;
      frames_drop  <= '0;
    end else begin
      hdr_valid <= 1'b0;
      err_short <= 1'b0;
      err_len   <= 1'b0;
      if (hdr_beat) begin
        hdr_sr   <= hdr_full[HDR_W-9:0];
        byte_cnt <= beat_idx + 3'd1;
        if (beat_idx == 3'(UDP_HDR_BYTES - 1)) begin
          UDP_SrcPort  <= hdr_field(hdr_full, SRC_OFF);
          UDP_DestPort <= hdr_dest;
          UDP_TotLen   <= hdr_len;
          UDP_CheckSum <= hdr_field(hdr_full, CSUM_OFF);
          hdr_valid    <= 1'b1;
          port_idx     <= (FILTER_EN && match_hit) ? match_idx : 3'd0;
          if (hdr_len < 16'(UDP_HDR_BYTES)) begin
            err_len <= 1'b1;
            if (udp_enable) frames_drop <= sat_inc(frames_drop);
            state <= s_axis_tlast ? IDLE : DROP;
          end else if (!accept) begin
            if (udp_enable) frames_drop <= sat_inc(frames_drop);
            state <= s_axis_tlast ? IDLE : DROP;
          end else if (hdr_len == 16'(UDP_HDR_BYTES)) begin
            if (udp_enable) frames_ok <= sat_inc(frames_ok);
            state <= s_axis_tlast ? IDLE : DROP;
          end else if (s_axis_tlast) begin
            err_short <= 1'b1;
            if (udp_enable) frames_drop <= sat_inc(frames_drop);
            state <= IDLE;
          end else begin
            rem   <= hdr_len - 16'(UDP_HDR_BYTES);
            first <= 1'b1;
            state <= DATA;
          end
        end else if (s_axis_tlast) begin
          err_short <= 1'b1;
          if (udp_enable) frames_drop <= sat_inc(frames_drop);
          state <= IDLE;
        end else begin
          state <= HEADER;
        end
      end else if (xfer) begin
        case (state)
          DATA: begin
            first <= 1'b0;
            rem   <= rem - 16'd1;
            if (rem == 16'd1) begin
              if (udp_enable) frames_ok <= sat_inc(frames_ok);
              state <= s_axis_tlast ? IDLE : DROP;
            end else if (s_axis_tlast) begin
              err_short <= 1'b1;
              if (udp_enable) frames_drop <= sat_inc(frames_drop);
              state <= IDLE;
            end
          end
          DROP:    if (s_axis_tlast) state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  axis_out_reg #(.DATA_W(8)) u_out (
    .clk        (s_axis_aclk),
    .rst        (s_axis_rst),
    .in_data    (s_axis_tdata),
    .in_valid   ((state == DATA) && xfer),
    .in_last    (s_axis_tlast || (rem == 16'd1)),
    .in_user    (first),
    .in_ready_c (or_ready_c),
    .out_data   (or_data),
    .out_valid  (or_valid),
    .out_last   (or_last),
    .out_user   (or_user),
    .out_ready  (or_out_ready)
  );

  // Bypass muxes: with the layer disabled the stream passes straight through.
  assign m_axis_tdata  = udp_enable ? or_data  : s_axis_tdata;
  assign m_axis_tvalid = udp_enable ? or_valid : s_axis_tvalid;
  assign m_axis_tlast  = udp_enable ? or_last  : s_axis_tlast;
  assign m_axis_tuser  = udp_enable ? or_user  : s_axis_tuser;

endmodule
